rider_steer_seq: RTL
====================

// Module: rider_steer_seq
// PURPOSE
//  Sequences rider detection and steering enable for the balance controller.
//  Samples left/right load-cell readings from A2D_intf, detects rider mount and dismount with
//   hysteresis, and times a steady-stance interval before enabling steering.
//  Drives rider_off (PID integrator clear) and en_steer (SegwayMath steer enable) into balance_cntrl.
// PARAMETERS
//  fast_sim     1       1: stance timer is 15 bits (32768 clk); 0: 26 bits (~1.34 s at 50 MHz)
//  MIN_RIDER_WT 13'h200 sum threshold for rider-on
//  WT_HYST      13'h040 rider-off when sum < MIN_RIDER_WT - WT_HYST
//  DB_CYC       16'd1024 rider_off debounce length, used only with RIDER_DEBOUNCE_EN
// PORTS
//  clk        in   1   system clock, 50 MHz
//  rst        in   1   asynchronous active-high reset
//  pwr_up     in   1   balance control powered; low forces IDLE
//  ld_vld     in   1   one-cycle strobe, lft_ld/rght_ld valid
//  lft_ld     in   12  left load cell, unsigned
//  rght_ld    in   12  right load cell, unsigned
//  en_steer   out  1   steering enabled (to balance_cntrl)
//  rider_off  out  1   no rider present (to balance_cntrl)
//  seq_state  out  2   current state: 0 IDLE, 1 WAIT, 2 STEER
// BEHAVIOUR
//  Reset: lft_q = rght_q = 0, state = IDLE, tmr = 0, present = 0, en_steer = 0, rider_off = 1.
//  Load capture: lft_q/rght_q load on ld_vld, otherwise hold. All decisions use the held values.
//  Arithmetic (combinational on held values):
//   - sum  = lft_q + rght_q, 13-bit unsigned.
//   - diff = |lft_q - rght_q|, 12-bit unsigned.
//   - diff_gt_1_4   = diff > (sum >> 2).
//   - diff_gt_15_16 = diff > (sum - (sum >> 4)), 13-bit compare.
//  present flop:
//   - Sets when sum >= MIN_RIDER_WT.
//   - Clears when sum < MIN_RIDER_WT - WT_HYST.
//   - Holds between the two thresholds.
//  tmr: saturating up-counter; tmr_full = all ones; cleared wherever marked "clr".
//  FSM (registered):
//   - Any state, pwr_up = 0 -> IDLE, clr.
//   - IDLE: present -> WAIT, clr.
//   - WAIT: !present -> IDLE. Else diff_gt_1_4 -> stay, clr. Else tmr_full -> STEER. Else tmr++.
//   - STEER: !present -> IDLE. Else diff_gt_15_16 -> WAIT, clr. Else stay.
//  Priority: !pwr_up > !present > diff checks > tmr_full.
//  en_steer = (state == STEER) from the state flop; high the cycle after entering STEER.
//  rider_off: flop, next = !present | !pwr_up; one clk lag behind present.
//  Timing from the ld_vld edge:
//   - present updates 1 clk after the ld_vld edge.
//   - state updates 1 clk after present.
//  Reset mid-operation: all flops return to reset values asynchronously.
//  Operation resumes from IDLE on the first clk after rst deasserts.
// CONFIGURATION
//  RIDER_DEBOUNCE_EN defined:
//   - rider_off rises only after !present | !pwr_up has held for DB_CYC consecutive clk.
//   - rider_off falls immediately.
//   - FSM still leaves STEER/WAIT on the first !present.
//  RIDER_DEBOUNCE_EN undefined: rider_off behaves as above, no counter is instantiated.
// TESTING (fast_sim = 1, defaults, macro undefined unless stated)
//  Reset: rst = 1 -> en_steer = 0, rider_off = 1, seq_state = 0; held for any ld values.
//  Mount:
//   - Stimulus: pwr_up = 1, ld_vld with lft = rght = 12'h180 (sum 0x300).
//   - rider_off = 0 after 2 clk; seq_state = 1.
//   - 32768 clk later seq_state = 2, then en_steer = 1 one clk after.
//  Lean restarts timer: in WAIT at tmr ~20000, load lft = 12'h300, rght = 12'h080 (diff 0x280 > 0xE0).
//   - tmr clears; en_steer stays 0.
//   - Restore balance -> en_steer only after a further 32768 clk.
//  Step-off: in STEER, load lft = 12'h300, rght = 0 (diff 0x300 > 0x2D0).
//   - Required: seq_state = 1, en_steer = 0, rider_off stays 0.
//  Hysteresis and dismount:
//   - sum = 0x1D0 (between thresholds): present holds.
//   - sum = 0x1B0: IDLE, rider_off = 1; pwr_up drop in STEER gives the same result.
//  RIDER_DEBOUNCE_EN: dismount -> rider_off stays 0 for 1023 clk, rises at clk 1024.
//   - A remount inside that window leaves rider_off at 0.

Source files
------------

// File: rtl/rider_steer_seq.sv
// Rider mount/dismount detection with hysteresis and stance timer gating steering enable.
// Latency: present 1 clk after load capture, state/rider_off 1 clk later, en_steer 1 clk after state. Optional macro: RIDER_DEBOUNCE_EN.
module rider_steer_seq #(
    parameter int          fast_sim     = 1,
    parameter logic [12:0] MIN_RIDER_WT = 13'h200,
    parameter logic [12:0] WT_HYST      = 13'h040,
    parameter logic [15:0] DB_CYC       = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwr_up,
    input  logic        ld_vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off,
    output logic [1:0]  seq_state
);

    localparam int          TMR_W  = (fast_sim != 0) ? 15 : 26;
    localparam logic [12:0] OFF_WT = MIN_RIDER_WT - WT_HYST;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STEER = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [11:0]        lft_q, rght_q;
    logic [12:0]        sum, sum_15_16;
    logic [11:0]        diff;
    logic               diff_gt_1_4, diff_gt_15_16;
    logic               present;
    logic [TMR_W-1:0]   tmr;
    logic               tmr_full, tmr_clr, tmr_inc;
    logic               off_cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_q  <= '0;
            rght_q <= '0;
        end else if (ld_vld) begin
            lft_q  <= lft_ld;
            rght_q <= rght_ld;
        end
    end

    always_comb begin
        sum           = {1'b0, lft_q} + {1'b0, rght_q};
        diff          = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
        sum_15_16     = sum - (sum >> 4);
        diff_gt_1_4   = {1'b0, diff} > (sum >> 2);
        diff_gt_15_16 = {1'b0, diff} > sum_15_16;
    end

    // Between the two thresholds the flop holds, giving mount/dismount hysteresis.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            present <= 1'b0;
        end else if (sum >= MIN_RIDER_WT) begin
            present <= 1'b1;
        end else if (sum < OFF_WT) begin
            present <= 1'b0;
        end
    end

    assign tmr_full = &tmr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= '0;
        end else if (tmr_clr) begin
            tmr <= '0;
        end else if (tmr_inc && !tmr_full) begin
            tmr <= tmr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_clr   = 1'b0;
        tmr_inc   = 1'b0;
        if (!pwr_up) begin
            state_nxt = IDLE;
            tmr_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (present) begin
                        state_nxt = WAIT;
                        tmr_clr   = 1'b1;
                    end
                end
                WAIT: begin
                    if (!present) begin
                        state_nxt = IDLE;
                    end else if (diff_gt_1_4) begin
                        tmr_clr = 1'b1;
                    end else if (tmr_full) begin
                        state_nxt = STEER;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
                STEER: begin
                    if (!present) begin
                        state_nxt = IDLE;
                    end else if (diff_gt_15_16) begin
                        state_nxt = WAIT;
                        tmr_clr   = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    tmr_clr   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_steer <= 1'b0;
        end else begin
            en_steer <= (state == STEER);
        end
    end

    assign off_cond  = !present || !pwr_up;
    assign seq_state = state;

`ifdef RIDER_DEBOUNCE_EN
    // Counter parks at DB_CYC-1 once rider_off is up so reset-state rider_off stays high.
    logic [15:0] db_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt    <= DB_CYC - 16'd1;
            rider_off <= 1'b1;
        end else if (!off_cond) begin
            db_cnt    <= '0;
            rider_off <= 1'b0;
        end else if (db_cnt >= DB_CYC - 16'd1) begin
            rider_off <= 1'b1;
        end else begin
            db_cnt <= db_cnt + 16'd1;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rider_off <= 1'b1;
        end else begin
            rider_off <= off_cond;
        end
    end
`endif

endmodule
